load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- CPU-side requester for the word-organised data memory: takes one load/store request per transaction from the datapath and drives a registered request/acknowledge interface toward data memory.
- Supports byte, halfword and word accesses (signed/unsigned loads) using byte enables, so sub-word stores need no read-modify-write.
- Sits between the EX/MEM stage and data memory; asserts Busy so the control unit can stall the pipeline.

Parameters:
- ADDR_W, 5, word-address width driven to memory (32 words)
- TIMEOUT, 16, max cycles to wait for MemAck before aborting (≥1)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request strobe, sampled only in IDLE
- MemRead  input  1  request is a load
- MemWrite  input  1  request is a store
- Size  input  2  00 byte, 01 half, 10 word, 11 reserved (error)
- Unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- Adress  input  32  byte address from ALU
- WriteD  input  32  store data; right-aligned for byte/half
- Busy  output  1  high from accepted Start until the Done cycle, inclusive
- Done  output  1  one-cycle completion pulse
- Error  output  1  valid with Done: misaligned, reserved Size, illegal command, or timeout
- Rdata  output  32  extended load result
- MemReq  output  1  request to memory
- MemWe  output  1  1 store, 0 load; valid while MemReq
- MemAddr  output  ADDR_W  word address = Adress[ADDR_W+1:2]
- MemBe  output  4  byte enables, lane i = bits 8i+7:8i (little-endian)
- MemWData  output  32  lane-replicated store data
- MemRData  input  32  memory read word, valid with MemAck
- MemAck  input  1  completion from memory, one cycle

Behaviour:
- Reset: state IDLE; Busy, Done, Error, MemReq, MemWe = 0; MemBe = 0; MemAddr, MemWData, Rdata = 0. A reset during any state aborts the transaction with no Done pulse.
- States: IDLE, REQ, FIN.
- IDLE:
  - Start=1 with exactly one of MemRead/MemWrite high, Size≠11, and aligned address (half: Adress[0]=0; word: Adress[1:0]=00) → register MemAddr, MemBe, MemWData, MemWe; MemReq=1 and Busy=1 next cycle; go to REQ.
  - Start=1 with illegal command (both or neither high), reserved Size, or misalignment → no memory access; go to FIN with Error=1.
  - Start=0 → stay in IDLE.
- Byte enables:
  - byte: one-hot on Adress[1:0]
  - half: 0011 when Adress[1]=0, 1100 when Adress[1]=1
  - word: 1111
  - Loads also drive MemBe (informational).
- Store data replication:
  - byte: {4{WriteD[7:0]}}
  - half: {2{WriteD[15:0]}}
  - word: WriteD
- REQ:
  - MemReq held high with stable MemAddr, MemBe, MemWData, MemWe until MemAck is sampled high.
  - On MemAck: MemReq=0 next cycle. For loads, extract the lane selected by the registered address bits, extend per Unsigned, and register into Rdata. Go to FIN with Error=0.
  - A wait counter increments each REQ cycle. If TIMEOUT cycles pass without MemAck: MemReq=0, go to FIN with Error=1, Rdata unchanged.
  - MemAck in IDLE or FIN is ignored.
- FIN: Done=1 and Busy=1 for exactly one cycle, then IDLE. Start is ignored in FIN.
- Minimum latency with zero-wait memory: Start at cycle 0 → MemReq at cycle 1 → MemAck at cycle 1 → Done at cycle 2. Back-to-back Start is accepted in the cycle after Done.
- Rdata changes only on a successful load and holds between transactions. Stores and errors leave it unchanged.

Test Plan:
- Word store/load: store Adress=0x0C, WriteD=0xDEADBEEF, Size=10 → MemAddr=3, MemBe=1111, MemWData=0xDEADBEEF, MemWe=1. Then load the same address (memory model returns 0xDEADBEEF) → Rdata=0xDEADBEEF, Done at cycle 2, Error=0.
- Byte store: Adress=0x06, WriteD=0x000000A5, Size=00 → MemAddr=1, MemBe=0100, MemWData=0xA5A5A5A5.
- Signed/unsigned loads with MemRData=0x80F17F00:
  - Adress=0x02 byte signed → 0xFFFFFFF1
  - Adress=0x02 byte unsigned → 0x000000F1
  - Adress=0x02 half signed → 0xFFFF80F1
  - Adress=0x00 half unsigned → 0x00007F00
- Errors: word at 0x05, half at 0x03, Size=11, and MemRead=MemWrite=1 → MemReq never asserted, Done=1 with Error=1 at cycle 1, Rdata unchanged.
- Wait states/timeout: MemAck after 3 cycles → Done 1 cycle later with Error=0. MemAck never asserted → MemReq drops after 16 cycles, Done=1 with Error=1.
- Reset while in REQ → next cycle MemReq=0, Busy=0, no Done. A following Start is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store requester toward a word-organised data memory.
// Accepts one request per transaction, validates it, drives a registered
// req/ack handshake with byte enables, and returns an extended load result.
module load_store_unit #(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        Size,
   input  logic              Unsigned,
   input  logic [31:0]       Adress,
   input  logic [31:0]       WriteD,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [31:0]       Rdata,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [3:0]        MemBe,
   output logic [31:0]       MemWData,
   input  logic [31:0]       MemRData,
   input  logic              MemAck
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] wait_reg;
   logic [1:0]       off_reg;
   logic [1:0]       size_reg;
   logic             unsigned_reg;

   logic             cmd_ok, size_ok, align_ok, legal;
   logic [3:0]       be_dec;
   logic [31:0]      wd_dec;
   logic [31:0]      load_ext;
   logic [7:0]       lane_byte;
   logic [15:0]      lane_half;
   logic             timeout_hit;
   logic             unused_addr_bits;

   // Upper address bits lie outside the memory window and are not decoded.
   assign unused_addr_bits = ^Adress[31:ADDR_W+2];

   // Busy spans every non-idle cycle; Done marks the single FIN cycle.
   assign Busy = (state_reg != IDLE);
   assign Done = (state_reg == FIN);

   assign timeout_hit = (wait_reg == CNT_W'(TIMEOUT - 1));

   // Request validation, byte-enable and store-lane decode from live inputs.
   always_comb begin
      cmd_ok   = MemRead ^ MemWrite;
      size_ok  = (Size != 2'b11);
      align_ok = 1'b1;
      be_dec   = 4'b1111;
      wd_dec   = WriteD;
      case (Size)
         2'b00: begin
            be_dec = 4'b0001 << Adress[1:0];
            wd_dec = {4{WriteD[7:0]}};
         end
         2'b01: begin
            align_ok = ~Adress[0];
            be_dec   = Adress[1] ? 4'b1100 : 4'b0011;
            wd_dec   = {2{WriteD[15:0]}};
         end
         2'b10: begin
            align_ok = (Adress[1:0] == 2'b00);
         end
         default: begin
            align_ok = 1'b1;
         end
      endcase
      legal = cmd_ok & size_ok & align_ok;
   end

   // Select the addressed lane of the returned word and extend it.
   always_comb begin
      lane_byte = MemRData[8*off_reg +: 8];
      lane_half = off_reg[1] ? MemRData[31:16] : MemRData[15:0];
      case (size_reg)
         2'b00:   load_ext = {{24{~unsigned_reg & lane_byte[7]}}, lane_byte};
         2'b01:   load_ext = {{16{~unsigned_reg & lane_half[15]}}, lane_half};
         default: load_ext = MemRData;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: legal requests go to memory, bad ones finish at once.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (Start) state_next = legal ? REQ : FIN;
         end
         REQ: begin
            if (MemAck || timeout_hit) state_next = FIN;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered memory interface, error flag, wait counter and load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         MemReq       <= 1'b0;
         MemWe        <= 1'b0;
         MemAddr      <= '0;
         MemBe        <= 4'b0000;
         MemWData     <= 32'h0;
         Rdata        <= 32'h0;
         Error        <= 1'b0;
         wait_reg     <= '0;
         off_reg      <= 2'b00;
         size_reg     <= 2'b00;
         unsigned_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               Error <= 1'b0;
               if (Start) begin
                  if (legal) begin
                     MemReq       <= 1'b1;
                     MemWe        <= MemWrite;
                     MemAddr      <= Adress[ADDR_W+1:2];
                     MemBe        <= be_dec;
                     MemWData     <= wd_dec;
                     off_reg      <= Adress[1:0];
                     size_reg     <= Size;
                     unsigned_reg <= Unsigned;
                     wait_reg     <= '0;
                  end else begin
                     Error <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (MemAck) begin
                  MemReq <= 1'b0;
                  Error  <= 1'b0;
                  if (!MemWe) Rdata <= load_ext;
               end else if (timeout_hit) begin
                  MemReq <= 1'b0;
                  Error  <= 1'b1;
               end else begin
                  wait_reg <= wait_reg + CNT_W'(1);
               end
            end
            FIN: begin
               Error <= 1'b0;
            end
            default: begin
               MemReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a queue-based scoreboard and a
// simple memory responder driven inline with each transaction.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start, MemRead, MemWrite, Unsigned;
   logic [1:0]  Size;
   logic [31:0] Adress, WriteD;
   logic        Busy, Done, Error;
   logic [31:0] Rdata;
   logic        MemReq, MemWe;
   logic [4:0]  MemAddr;
   logic [3:0]  MemBe;
   logic [31:0] MemWData, MemRData;
   logic        MemAck;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          done_cyc;
      int          req_cyc;
   } exp_t;

   exp_t sb[$];

   load_store_unit #(.ADDR_W(5), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MemRead(MemRead),
      .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned), .Adress(Adress),
      .WriteD(WriteD), .Busy(Busy), .Done(Done), .Error(Error), .Rdata(Rdata),
      .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
      .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction: push expectation, drive Start, answer MemReq after
   // ack_dly request cycles (-1 = never), pop and compare on Done.
   task automatic run(input string name, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int ack_dly, input logic [31:0] memdata,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input logic [4:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic chk_wd,
                      input int exp_done, input int exp_req);
      exp_t e, got_e;
      int   req_n = 0;
      bit   got = 0;
      e.err = exp_err; e.rdata = exp_rdata; e.done_cyc = exp_done; e.req_cyc = exp_req;
      sb.push_back(e);
      @(negedge clk);
      chk({name, "_idle_busy"}, 32'(Busy), 32'h0);
      Start = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
      Adress = addr; WriteD = wd;
      @(posedge clk);
      #1 Start = 1'b0;
      for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
         @(negedge clk);
         if (MemReq) begin
            if (req_n == 0) begin
               chk({name, "_addr"}, 32'(MemAddr), 32'(exp_addr));
               chk({name, "_be"},   32'(MemBe),   32'(exp_be));
               chk({name, "_we"},   32'(MemWe),   32'(wr));
               if (chk_wd) chk({name, "_wdata"}, MemWData, exp_wd);
            end
            if (req_n == ack_dly) begin
               MemAck = 1'b1; MemRData = memdata;
            end else begin
               MemAck = 1'b0; MemRData = $urandom;
            end
            req_n++;
         end else begin
            MemAck = 1'b0;
         end
         if (Done) begin
            got = 1;
            got_e = sb.pop_front();
            chk({name, "_done_cyc"}, 32'(cyc), 32'(got_e.done_cyc));
            chk({name, "_err"},      32'(Error), 32'(got_e.err));
            chk({name, "_rdata"},    Rdata, got_e.rdata);
            chk({name, "_req_cyc"},  32'(req_n), 32'(got_e.req_cyc));
            chk({name, "_busy_done"}, 32'(Busy), 32'h1);
         end
      end
      MemAck = 1'b0;
      if (!got) begin
         chk({name, "_no_done"}, 32'h0, 32'h1);
         void'(sb.pop_front());
      end
      $display("txn %s: req_cycles=%0d err=%0b rdata=%h", name, req_n, Error, Rdata);
   endtask

   initial begin
      reset = 1'b1; Start = 0; MemRead = 0; MemWrite = 0; Size = 0; Unsigned = 0;
      Adress = 0; WriteD = 0; MemRData = 0; MemAck = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy",  32'(Busy),   0);
      chk("rst_done",  32'(Done),   0);
      chk("rst_err",   32'(Error),  0);
      chk("rst_req",   32'(MemReq), 0);
      chk("rst_we",    32'(MemWe),  0);
      chk("rst_be",    32'(MemBe),  0);
      chk("rst_addr",  32'(MemAddr), 0);
      chk("rst_wdata", MemWData, 0);
      chk("rst_rdata", Rdata, 0);

      //    name           rd wr sz     u  addr   wdata         ack mem           err rdata          addr be       wd            cw done req
      run("st_word",       0, 1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 0, 32'h0,        0, 32'h00000000, 3, 4'b1111, 32'hDEADBEEF, 1, 2, 1);
      run("ld_word",       1, 0, 2'b10, 0, 32'h0C, 32'h0,        0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 4'b1111, 32'h0,        0, 2, 1);
      run("st_byte",       0, 1, 2'b00, 0, 32'h06, 32'h000000A5, 0, 32'h0,        0, 32'hDEADBEEF, 1, 4'b0100, 32'hA5A5A5A5, 1, 2, 1);
      run("st_half_hi",    0, 1, 2'b01, 0, 32'h0A, 32'h12343C5A, 1, 32'h0,        0, 32'hDEADBEEF, 2, 4'b1100, 32'h3C5A3C5A, 1, 3, 2);
      run("ld_b_s",        1, 0, 2'b00, 0, 32'h02, 32'h0,        0, 32'h80F17F00, 0, 32'hFFFFFFF1, 0, 4'b0100, 32'h0,        0, 2, 1);
      run("ld_b_u",        1, 0, 2'b00, 1, 32'h02, 32'h0,        0, 32'h80F17F00, 0, 32'h000000F1, 0, 4'b0100, 32'h0,        0, 2, 1);
      run("ld_h_s",        1, 0, 2'b01, 0, 32'h02, 32'h0,        0, 32'h80F17F00, 0, 32'hFFFF80F1, 0, 4'b1100, 32'h0,        0, 2, 1);
      run("ld_h_u",        1, 0, 2'b01, 1, 32'h00, 32'h0,        0, 32'h80F17F00, 0, 32'h00007F00, 0, 4'b0011, 32'h0,        0, 2, 1);
      run("ld_b3_s",       1, 0, 2'b00, 0, 32'h7B, 32'h0,        0, 32'h7F000000, 0, 32'h0000007F, 30, 4'b1000, 32'h0,       0, 2, 1);
      run("err_word_mis",  1, 0, 2'b10, 0, 32'h05, 32'h0,        0, 32'h0,        1, 32'h0000007F, 0, 4'b0000, 32'h0,        0, 1, 0);
      run("err_half_mis",  0, 1, 2'b01, 0, 32'h03, 32'h1,        0, 32'h0,        1, 32'h0000007F, 0, 4'b0000, 32'h0,        0, 1, 0);
      run("err_size11",    1, 0, 2'b11, 0, 32'h00, 32'h0,        0, 32'h0,        1, 32'h0000007F, 0, 4'b0000, 32'h0,        0, 1, 0);
      run("err_both",      1, 1, 2'b10, 0, 32'h00, 32'h0,        0, 32'h0,        1, 32'h0000007F, 0, 4'b0000, 32'h0,        0, 1, 0);
      run("err_neither",   0, 0, 2'b10, 0, 32'h00, 32'h0,        0, 32'h0,        1, 32'h0000007F, 0, 4'b0000, 32'h0,        0, 1, 0);
      run("ld_wait3",      1, 0, 2'b10, 0, 32'h10, 32'h0,        3, 32'h12345678, 0, 32'h12345678, 4, 4'b1111, 32'h0,        0, 5, 4);
      run("ld_timeout",    1, 0, 2'b10, 0, 32'h14, 32'h0,       -1, 32'h0,        1, 32'h12345678, 5, 4'b1111, 32'h0,        0, 17, 16);
      run("ack_last",      1, 0, 2'b10, 0, 32'h18, 32'h0,       15, 32'hCAFEF00D, 0, 32'hCAFEF00D, 6, 4'b1111, 32'h0,        0, 17, 16);

      // Reset while the request is outstanding.
      @(negedge clk);
      Start = 1'b1; MemRead = 1; MemWrite = 0; Size = 2'b10; Adress = 32'h0C;
      @(posedge clk);
      #1 Start = 1'b0;
      @(negedge clk);
      chk("rreq_active", 32'(MemReq), 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rreq_req",  32'(MemReq), 0);
      chk("rreq_busy", 32'(Busy),   0);
      chk("rreq_done", 32'(Done),   0);
      @(negedge clk);
      chk("rreq_done2", 32'(Done),  0);
      $display("txn reset_in_req: req=%0b busy=%0b", MemReq, Busy);
      run("after_rst",     1, 0, 2'b01, 1, 32'h0E, 32'h0,        0, 32'hBEEF1234, 0, 32'h0000BEEF, 3, 4'b1100, 32'h0,        0, 2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
